// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and oversampling constants
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK = 7;
endpackage

// File: rtl/fifo_fwft.sv
// fifo_fwft: first-word-fall-through fifo with registered empty/full flags
module fifo_fwft #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] w_ptr, r_ptr, w_nxt, r_nxt;
    logic do_wr, do_rd;
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);
    assign w_nxt = w_ptr + ADDR_W'(1);
    assign r_nxt = r_ptr + ADDR_W'(1);
    assign r_data = empty ? '0 : mem[r_ptr];
    always_ff @(posedge clk)
        if (do_wr) mem[w_ptr] <= w_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (do_wr) w_ptr <= w_nxt;
            if (do_rd) r_ptr <= r_nxt;
            if (do_wr && !do_rd) begin
                empty <= 1'b0;
                full  <= w_nxt == r_ptr;
            end else if (do_rd && !do_wr) begin
                full  <= 1'b0;
                empty <= r_nxt == w_ptr;
            end
        end
    end
endmodule

// File: rtl/uart_rx_path.sv
// uart_rx_path: 16x oversampled uart receiver with baud tick generator feeding a fwft fifo
module uart_rx_path
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [10:0]     dvsr,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
    output logic            overrun
);
    localparam int NW = $clog2(DBIT);
    logic [1:0] sync;
    logic rx_s, tick, push;
    logic [10:0] cnt;
    rx_state_t state;
    logic [3:0] s;
    logic [NW-1:0] n;
    logic [DBIT-1:0] b;
    assign rx_s = sync[1];
    assign tick = cnt >= dvsr;
    assign push = state == STOP && tick && s == 4'(SB_TICK-1) && rx_s;
    always_ff @(posedge clk)
        sync <= reset ? 2'b11 : {sync[0], rx};
    always_ff @(posedge clk)
        cnt <= reset || tick ? '0 : cnt + 11'd1;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            b         <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= push & rx_full & ~rd_uart;
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    s     <= '0;
                end
                START: if (tick) begin
                    if (s == 4'(MID_TICK)) begin
                        state <= rx_s ? IDLE : DATA;
                        s     <= '0;
                        n     <= '0;
                    end else s <= s + 4'd1;
                end
                DATA: if (tick) begin
                    if (s == 4'(OVERSAMPLE-1)) begin
                        b <= {rx_s, b[DBIT-1:1]};
                        s <= '0;
                        if (n == NW'(DBIT-1)) state <= STOP;
                        else n <= n + NW'(1);
                    end else s <= s + 4'd1;
                end
                STOP: if (tick) begin
                    if (s == 4'(SB_TICK-1)) begin
                        state     <= IDLE;
                        s         <= '0;
                        frame_err <= ~rx_s;
                    end else s <= s + 4'd1;
                end
            endcase
        end
    end
    fifo_fwft #(.DATA_W(DBIT), .ADDR_W(FIFO_W)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (push),
        .rd     (rd_uart),
        .w_data (b),
        .r_data (r_data),
        .empty  (rx_empty),
        .full   (rx_full)
    );
endmodule

// File: tb/tb_uart_rx_path.sv
// tb_uart_rx_path: scoreboard bench for uart_rx_path with a 4-entry fifo
module tb_uart_rx_path;
    logic clk = 1'b0;
    logic reset, rx, rd_uart;
    logic [10:0] dvsr;
    logic [7:0] r_data;
    logic rx_empty, rx_full, frame_err, overrun;
    int total = 0, bad = 0;
    int fe_cnt = 0, ov_cnt = 0;
    logic [7:0] sb[$];

    uart_rx_path #(.DBIT(8), .SB_TICK(16), .FIFO_W(2)) dut (
        .clk(clk), .reset(reset), .dvsr(dvsr), .rx(rx), .rd_uart(rd_uart),
        .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    task automatic send_byte(input logic [7:0] d, input logic stop, input int cpb, input int stop_len);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (i == 9 ? stop_len : cpb) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic drain(input int k);
        logic [7:0] exp;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            exp = sb.size() != 0 ? sb.pop_front() : 8'h00;
            total++;
            if (rx_empty !== 1'b0 || r_data !== exp) begin
                bad++;
                $display("FAIL drain[%0d]: empty=%b r_data=%h, need empty=0 r_data=%h", i, rx_empty, r_data, exp);
            end
            rd_uart = 1'b1;
            @(posedge clk);
            #1 rd_uart = 1'b0;
        end
    endtask

    task automatic expect_empty(input string name);
        @(negedge clk);
        total++;
        if (rx_empty !== 1'b1 || r_data !== 8'h00) begin
            bad++;
            $display("FAIL %s: empty=%b r_data=%h, need empty=1 r_data=00", name, rx_empty, r_data);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total += 5;
        if (rx_empty !== 1'b1) begin bad++; $display("FAIL %s rx_empty: got %b need 1", name, rx_empty); end
        if (rx_full !== 1'b0) begin bad++; $display("FAIL %s rx_full: got %b need 0", name, rx_full); end
        if (r_data !== 8'h00) begin bad++; $display("FAIL %s r_data: got %h need 00", name, r_data); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL %s frame_err: got %b need 0", name, frame_err); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL %s overrun: got %b need 0", name, overrun); end
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; rd_uart = 1'b0; dvsr = 11'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("in_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        send_byte(8'h55, 1'b1, 64, 64);
        sb.push_back(8'h55);
        drain(1);
        expect_empty("single_after_pop");
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx = 1'b1;
        repeat (64 * 4) @(posedge clk);
        #1;
        total++;
        if (fe_cnt !== fe0) begin bad++; $display("FAIL glitch frame_err: pulses=%0d need 0", fe_cnt - fe0); end
        expect_empty("glitch_no_push");
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        send_byte(8'hA3, 1'b0, 64, 44);
        repeat (64 * 3) @(posedge clk);
        #1;
        total++;
        if (fe_cnt !== fe0 + 1) begin bad++; $display("FAIL frame_err pulse: cycles=%0d need 1", fe_cnt - fe0); end
        expect_empty("frame_err_no_push");
    endtask

    task automatic test_overrun();
        int ov0;
        for (int v = 1; v <= 4; v++) begin
            send_byte(8'(v), 1'b1, 64, 64);
            sb.push_back(8'(v));
        end
        @(negedge clk);
        total++;
        if (rx_full !== 1'b1) begin bad++; $display("FAIL overrun full_after_4: got %b need 1", rx_full); end
        ov0 = ov_cnt;
        send_byte(8'h05, 1'b1, 64, 64);
        total++;
        if (ov_cnt !== ov0 + 1) begin bad++; $display("FAIL overrun pulse: cycles=%0d need 1", ov_cnt - ov0); end
        drain(4);
        expect_empty("overrun_drained");
    endtask

    task automatic test_latency();
        dvsr = 11'd0;
        repeat (4) @(posedge clk);
        #1;
        fork
            send_byte(8'h3C, 1'b1, 16, 16);
            begin
                repeat (154) @(posedge clk);
                @(negedge clk);
                total++;
                if (rx_empty !== 1'b1) begin bad++; $display("FAIL latency before_push: empty=%b need 1", rx_empty); end
                @(negedge clk);
                total++;
                if (rx_empty !== 1'b0 || r_data !== 8'h3C) begin
                    bad++;
                    $display("FAIL latency after_push: empty=%b r_data=%h need 0/3c", rx_empty, r_data);
                end
            end
        join
        sb.push_back(8'h3C);
        drain(1);
        expect_empty("latency_drained");
    endtask

    task automatic test_back_to_back();
        int ov0;
        logic [7:0] exp;
        @(posedge clk);
        #1;
        for (int v = 8'h10; v <= 8'h13; v++) begin
            send_byte(8'(v), 1'b1, 16, 16);
            sb.push_back(8'(v));
        end
        ov0 = ov_cnt;
        fork
            send_byte(8'h77, 1'b1, 16, 16);
            begin
                repeat (154) @(posedge clk);
                #1 rd_uart = 1'b1;
                @(negedge clk);
                exp = sb.pop_front();
                total++;
                if (rx_full !== 1'b1 || r_data !== exp) begin
                    bad++;
                    $display("FAIL b2b head_at_push: full=%b r_data=%h need 1/%h", rx_full, r_data, exp);
                end
                @(posedge clk);
                #1 rd_uart = 1'b0;
                @(negedge clk);
                total++;
                if (rx_full !== 1'b1) begin bad++; $display("FAIL b2b still_full: got %b need 1", rx_full); end
            end
        join
        sb.push_back(8'h77);
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (ov_cnt !== ov0) begin bad++; $display("FAIL b2b overrun: cycles=%0d need 0", ov_cnt - ov0); end
        drain(4);
        expect_empty("b2b_drained");
    endtask

    task automatic test_reset_mid_frame();
        dvsr = 11'd3;
        rx = 1'b0;
        repeat (64 * 3) @(posedge clk);
        #1 begin reset = 1'b1; rx = 1'b1; end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("mid_frame_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (64) @(posedge clk);
        #1;
        expect_empty("aborted_frame_no_push");
        @(posedge clk);
        #1;
        send_byte(8'hC4, 1'b1, 64, 64);
        sb.push_back(8'hC4);
        drain(1);
        expect_empty("resync_drained");
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_latency();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
